reciprocal_lut_builder: RTL and testbench
=========================================

// Module: reciprocal_lut_builder
// PURPOSE
//  Run-time writer for the reciprocal interpolation tables (slope m, intercept b) read by the 16.16 NUMERATOR/x unit.
//  On start, generates every subdivision entry with an exact sequential divider and streams it to LUT RAM write ports.
//  Replaces the static hex images, so NUMERATOR can change without regenerating files.
// PARAMETERS
//  NUMERATOR               32'h100  integer numerator of f(x)=NUMERATOR/x
//  NB_SUBDIVISIONS         2048     entries; power of 2, <=16384; SUBDIVISION_SIZE=16384/NB_SUBDIVISIONS (localparam)
//  NB_BITS_PER_SUBDIVISION 3        slope arithmetic shift (log2 SUBDIVISION_SIZE for the reader's 2^19 span)
//  ADDR_W (localparam)     $clog2(NB_SUBDIVISIONS)
// PORTS
//  clk          in   1       clock; all state changes on rising edge
//  reset_i      in   1       synchronous reset, active-high
//  start_i      in   1       1-cycle request to (re)build tables; sampled only in IDLE
//  busy_o       out  1       high from cycle after accepted start until DONE exits
//  done_o       out  1       1-cycle pulse after last entry written
//  lut_valid_o  out  1       write entry valid
//  lut_ready_i  in   1       LUT side accepts; write occurs when valid&&ready
//  lut_addr_o   out  ADDR_W  entry index i
//  lut_m_o      out  24      slope m[23:0] (signed, two's complement)
//  lut_b_o      out  32      intercept, unsigned 16.16
// BEHAVIOUR
//  Reset: state IDLE; busy_o=0, done_o=0, lut_valid_o=0, lut_addr_o=0, lut_m_o=0, lut_b_o=0.
//  Math: q(k)=floor((NUMERATOR<<16)/(k*SUBDIVISION_SIZE)) for k>=1 (truncating, unsigned); q(0)=NUMERATOR<<16.
//   b[i]=q(i); m[i]=(signed(q(i+1)-q(i)) >>> NB_BITS_PER_SUBDIVISION)[23:0]; 32-bit wrap on subtract.
//   One division per entry: q(i+1) computed, q(i) held in b_prev register; divisor never zero.
//  FSM: IDLE -start_i-> DIV (b_prev=NUMERATOR<<16, idx=0, divisor=SUBDIVISION_SIZE)
//   DIV: restoring divide, 1 quotient bit/cycle, exactly 32 cycles -> WRITE
//   WRITE: valid_o=1, addr/m/b stable until valid&&ready; on handshake:
//     idx==NB_SUBDIVISIONS-1 -> DONE; else b_prev=q, idx++, divisor+=SUBDIVISION_SIZE -> DIV
//   DONE: done_o=1 for 1 cycle, busy_o=0 -> IDLE.
//  Latency with ready tied high: done_o asserts 33*NB_SUBDIVISIONS+1 cycles after start_i cycle.
//  start_i while busy: ignored. start_i in DONE cycle: ignored.
//  lut_ready_i low in WRITE: stall indefinitely, outputs held; ready outside WRITE: no effect.
//  reset_i mid-operation: abort immediately; lut_valid_o=0 next cycle; no partial-entry write; table content undefined.
//  Addresses strictly ascending 0..NB_SUBDIVISIONS-1, each written exactly once per build.
// CONFIGURATION
//  RECIPROCAL_LUT_BUILDER_CHECKSUM_EN defined: extra port checksum_o out 32; cleared on accepted start,
//   adds {8'h00,m}+b (mod 2^32) per handshake; valid when done_o; reset value 0.
//  Not defined: port and accumulator absent; behaviour otherwise identical.
// STRUCTURE
//  reciprocal_pkg: fixed_t (logic[31:0] 16.16), slope_t (logic[23:0]), default NUMERATOR/NB_SUBDIVISIONS,
//   TABLE_RANGE=16384; shared with the reciprocal reader.
//  Sub-module seq_divider: unsigned 32/32 restoring divider, start/done, fixed 32-cycle latency, quotient only.
//  Top: FSM, idx counter, divisor accumulator, b_prev, slope subtract/shift, write handshake.
// TESTING
//  Defaults, ready=1, start -> entry0 m=24'hE40000 b=32'h01000000; entry1 m=24'hFE0000 b=32'h00200000.
//  Defaults -> entry2047 m=24'h000000 b=32'h00000400; done_o exactly 67585 cycles after start.
//  NB_SUBDIVISIONS=4, ready toggling 1/0 random -> 4 writes, addr 0..3 in order, fields stable while stalled.
//  Reset at 100 cycles into build -> valid_o=0 next cycle, busy_o=0; new start -> full 4-entry build from addr 0.
//  start_i pulsed during busy and in DONE cycle -> no restart, entry count unchanged.
//  CHECKSUM_EN, NB_SUBDIVISIONS=4 -> checksum_o equals model sum of {8'h00,m}+b at done_o.

Source files
------------

// File: rtl/reciprocal_pkg.sv
// reciprocal_pkg: types, defaults and slope helper shared by the reciprocal table builder and reader
package reciprocal_pkg;

    typedef logic [31:0] fixed_t;
    typedef logic [23:0] slope_t;

    localparam logic [31:0] DEFAULT_NUMERATOR       = 32'h100;
    localparam int          DEFAULT_NB_SUBDIVISIONS = 2048;
    localparam int          TABLE_RANGE             = 16384;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_WRITE,
        ST_DONE
    } build_state_e;

    // Slope between neighbouring sample points: 32-bit wrapping difference, arithmetic shift, low 24 bits kept
    function automatic slope_t slope_of(input fixed_t q_next, input fixed_t q_prev, input int unsigned shift);
        return slope_t'($signed(q_next - q_prev) >>> shift);
    endfunction

endpackage

// File: rtl/seq_divider.sv
// seq_divider: unsigned 32/32 restoring divider, one quotient bit per cycle, fixed 32-cycle latency
// done_o is high during the cycle whose closing edge writes the final quotient bit,
// so quotient_o holds the finished result from the following cycle onward.
module seq_divider (
    input  logic        clk,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        done_o,
    output logic [31:0] quotient_o
);

    logic [31:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] den_q, den_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [32:0] shifted;
    logic        fits;

    // One restoring step per cycle: shift the next dividend bit into the remainder and subtract if it fits
    always_comb begin
        shifted = {rem_q, quo_q[31]};
        fits    = shifted >= {1'b0, den_q};
        rem_d   = rem_q;
        quo_d   = quo_q;
        den_d   = den_q;
        cnt_d   = cnt_q;
        if (start_i) begin
            rem_d = '0;
            quo_d = dividend_i;
            den_d = divisor_i;
            cnt_d = 6'd32;
        end else if (cnt_q != 6'd0) begin
            rem_d = fits ? shifted[31:0] - den_q : shifted[31:0];
            quo_d = {quo_q[30:0], fits};
            cnt_d = cnt_q - 6'd1;
        end
    end

    // Divider state registers
    always_ff @(posedge clk) begin
        if (reset_i) begin
            quo_q <= '0;
            rem_q <= '0;
            den_q <= '0;
            cnt_q <= '0;
        end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            den_q <= den_d;
            cnt_q <= cnt_d;
        end
    end

    assign done_o     = cnt_q == 6'd1;
    assign quotient_o = quo_q;

endmodule

// File: rtl/reciprocal_lut_builder.sv
// reciprocal_lut_builder: computes slope/intercept entries of NUMERATOR/x and streams them to LUT write ports
// Optional RECIPROCAL_LUT_BUILDER_CHECKSUM_EN adds checksum_o, a running sum of {8'h00,m}+b over one build.
module reciprocal_lut_builder
    import reciprocal_pkg::*;
#(
    parameter logic [31:0] NUMERATOR               = DEFAULT_NUMERATOR,
    parameter int          NB_SUBDIVISIONS         = DEFAULT_NB_SUBDIVISIONS,
    parameter int          NB_BITS_PER_SUBDIVISION = 3,
    localparam int         ADDR_W                  = $clog2(NB_SUBDIVISIONS)
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              lut_valid_o,
    input  logic              lut_ready_i,
    output logic [ADDR_W-1:0] lut_addr_o,
    output logic [23:0]       lut_m_o,
    output logic [31:0]       lut_b_o
`ifdef RECIPROCAL_LUT_BUILDER_CHECKSUM_EN
    ,
    output logic [31:0]       checksum_o
`endif
);

    localparam fixed_t DIVIDEND = NUMERATOR << 16;
    localparam fixed_t SUB_SIZE = fixed_t'(TABLE_RANGE / NB_SUBDIVISIONS);

    build_state_e      state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    fixed_t            divisor_q, divisor_d;
    fixed_t            b_prev_q, b_prev_d;
    fixed_t            quotient;
    logic              div_done;
    logic              start_acc;
    logic              handshake;
    logic              last;
    logic              advance;

    assign start_acc = state_q == ST_IDLE && start_i;
    assign handshake = state_q == ST_WRITE && lut_ready_i;
    assign last      = idx_q == ADDR_W'(NB_SUBDIVISIONS - 1);
    assign advance   = handshake && !last;

    // q(i+1) is divided while q(i) sits in b_prev, so each entry costs exactly one division
    seq_divider u_div (
        .clk        (clk),
        .reset_i    (reset_i),
        .start_i    (start_acc || advance),
        .dividend_i (DIVIDEND),
        .divisor_i  (divisor_d),
        .done_o     (div_done),
        .quotient_o (quotient)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: divide, then hold the entry until the LUT side takes it
    always_comb begin
        unique case (state_q)
            ST_IDLE:  state_d = start_i ? ST_DIV : ST_IDLE;
            ST_DIV:   state_d = div_done ? ST_WRITE : ST_DIV;
            ST_WRITE: state_d = !lut_ready_i ? ST_WRITE : last ? ST_DONE : ST_DIV;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: entry fields come straight from the held registers, so they stay put while stalled
    always_comb begin
        busy_o      = state_q == ST_DIV || state_q == ST_WRITE;
        done_o      = state_q == ST_DONE;
        lut_valid_o = state_q == ST_WRITE;
        lut_addr_o  = idx_q;
        lut_b_o     = b_prev_q;
        lut_m_o     = slope_of(quotient, b_prev_q, NB_BITS_PER_SUBDIVISION);
    end

    // Datapath next state: restart from entry 0 on start, step index/divisor/intercept per accepted entry
    always_comb begin
        idx_d     = start_acc ? '0 : advance ? idx_q + ADDR_W'(1) : idx_q;
        divisor_d = start_acc ? SUB_SIZE : advance ? divisor_q + SUB_SIZE : divisor_q;
        b_prev_d  = start_acc ? DIVIDEND : advance ? quotient : b_prev_q;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset_i) begin
            idx_q     <= '0;
            divisor_q <= '0;
            b_prev_q  <= '0;
        end else begin
            idx_q     <= idx_d;
            divisor_q <= divisor_d;
            b_prev_q  <= b_prev_d;
        end
    end

`ifdef RECIPROCAL_LUT_BUILDER_CHECKSUM_EN
    logic [31:0] checksum_q, checksum_d;

    // Checksum accumulates every written entry of the current build
    always_comb begin
        checksum_d = start_acc ? '0 : handshake ? checksum_q + {8'h00, lut_m_o} + lut_b_o : checksum_q;
    end

    // Checksum register
    always_ff @(posedge clk) begin
        if (reset_i) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum_o = checksum_q;
`endif

endmodule

// File: tb/tb_reciprocal_lut_builder.sv
// tb_reciprocal_lut_builder: default-size table/latency checks plus randomized 4-entry builds against an arithmetic model
module tb_reciprocal_lut_builder;

    localparam int          NA    = 2048;
    localparam logic [31:0] NUM_A = 32'h100;
    localparam int          SH_A  = 3;
    localparam int          NB    = 4;
    localparam logic [31:0] NUM_B = 32'h3;
    localparam int          SH_B  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, start_a, rdy_a, busy_a, done_a, val_a;
    logic [10:0] addr_a;
    logic [23:0] m_a;
    logic [31:0] b_a;
    logic        rst_b, start_b, rdy_b, busy_b, done_b, val_b;
    logic [1:0]  addr_b;
    logic [23:0] m_b;
    logic [31:0] b_b;
`ifdef RECIPROCAL_LUT_BUILDER_CHECKSUM_EN
    logic [31:0] cs_a, cs_b;
`endif

    reciprocal_lut_builder dut_a (
        .clk(clk), .reset_i(rst_a), .start_i(start_a), .busy_o(busy_a), .done_o(done_a),
        .lut_valid_o(val_a), .lut_ready_i(rdy_a), .lut_addr_o(addr_a), .lut_m_o(m_a), .lut_b_o(b_a)
`ifdef RECIPROCAL_LUT_BUILDER_CHECKSUM_EN
        , .checksum_o(cs_a)
`endif
    );

    reciprocal_lut_builder #(.NUMERATOR(NUM_B), .NB_SUBDIVISIONS(NB), .NB_BITS_PER_SUBDIVISION(SH_B)) dut_b (
        .clk(clk), .reset_i(rst_b), .start_i(start_b), .busy_o(busy_b), .done_o(done_b),
        .lut_valid_o(val_b), .lut_ready_i(rdy_b), .lut_addr_o(addr_b), .lut_m_o(m_b), .lut_b_o(b_b)
`ifdef RECIPROCAL_LUT_BUILDER_CHECKSUM_EN
        , .checksum_o(cs_b)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: q(k) = floor((num<<16) / (k * 16384/n)), q(0) = num<<16
    function automatic logic [31:0] q_of(input logic [31:0] num, input int n, input int k);
        logic [31:0] top;
        top = num << 16;
        if (k == 0) return top;
        return 32'(longint'(top) / longint'(k * (16384 / n)));
    endfunction

    // Reference slope: wrapped 32-bit difference, divided by 2^sh rounding toward minus infinity
    function automatic logic [23:0] m_of(input logic [31:0] num, input int n, input int sh, input int k);
        logic [31:0] diff;
        longint      d, p, f;
        logic [63:0] t;
        diff = q_of(num, n, k + 1) - q_of(num, n, k);
        d    = longint'($signed(diff));
        p    = longint'(1) << sh;
        f    = d >= 0 ? d / p : -((-d + p - 1) / p);
        t    = f;
        return t[23:0];
    endfunction

    logic [23:0] got_m_a [NA];
    logic [31:0] got_b_a [NA];
    int          cnt_a = 0;

    always @(negedge clk) begin
        if (val_a && rdy_a) begin
            check("a_addr_order", 64'(addr_a), 64'(cnt_a));
            if (cnt_a < NA) begin
                got_m_a[cnt_a] = m_a;
                got_b_a[cnt_a] = b_a;
            end
            cnt_a++;
        end
    end

    int          cnt_b = 0;
    logic [31:0] sum_b = '0;
    logic        hold_b = 1'b0;
    logic [1:0]  h_addr;
    logic [23:0] h_m;
    logic [31:0] h_b;

    always @(negedge clk) begin
        if (val_b && hold_b) begin
            check("b_stall_addr", 64'(addr_b), 64'(h_addr));
            check("b_stall_m", 64'(m_b), 64'(h_m));
            check("b_stall_b", 64'(b_b), 64'(h_b));
        end
        if (val_b && rdy_b) begin
            check("b_addr", 64'(addr_b), 64'(cnt_b));
            check("b_m", 64'(m_b), 64'(m_of(NUM_B, NB, SH_B, cnt_b)));
            check("b_b", 64'(b_b), 64'(q_of(NUM_B, NB, cnt_b)));
            sum_b = sum_b + {8'h00, m_of(NUM_B, NB, SH_B, cnt_b)} + q_of(NUM_B, NB, cnt_b);
            cnt_b++;
        end
        hold_b = val_b && !rdy_b && !rst_b;
        h_addr = addr_b;
        h_m    = m_b;
        h_b    = b_b;
    end

    int rmode_b = 0;
    always @(posedge clk) begin
        #1;
        rdy_b = rmode_b == 1 ? 1'($urandom) : rmode_b == 0;
    end

    task automatic pulse_start_b();
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
    endtask

    task automatic wait_done_b(input int limit);
        int cyc;
        cyc = 0;
        while (!done_b && cyc < limit) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("b_done_seen", 64'(done_b), 64'd1);
    endtask

    typedef struct {
        int          idx;
        logic [23:0] m;
        logic [31:0] b;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int cyc;
        tbl.push_back('{0, 24'hE40000, 32'h01000000});
        tbl.push_back('{1, 24'hFE0000, 32'h00200000});
        tbl.push_back('{2047, 24'h000000, 32'h00000400});
        for (int i = 0; i < 9; i++) begin
            int k;
            k = $urandom_range(0, NA - 1);
            tbl.push_back('{k, m_of(NUM_A, NA, SH_A, k), q_of(NUM_A, NA, k)});
        end

        rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0; rdy_a = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0; rst_b = 1'b0;
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_done", 64'(done_a), 64'd0);
        check("rst_valid", 64'(val_a), 64'd0);
        check("rst_addr", 64'(addr_a), 64'd0);
        check("rst_m", 64'(m_a), 64'd0);
        check("rst_b", 64'(b_a), 64'd0);
        check("rst_b_valid", 64'(val_b), 64'd0);
`ifdef RECIPROCAL_LUT_BUILDER_CHECKSUM_EN
        check("rst_checksum", 64'(cs_a), 64'd0);
`endif

        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        cyc = 1;
        check("a_busy_after_start", 64'(busy_a), 64'd1);
        while (!done_a && cyc < 70000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("a_done_latency", 64'(cyc), 64'(33 * NA + 1));
        check("a_busy_in_done", 64'(busy_a), 64'd0);
        check("a_entry_count", 64'(cnt_a), 64'(NA));
        @(posedge clk); #1;
        check("a_done_one_cycle", 64'(done_a), 64'd0);
        foreach (tbl[i]) begin
            check($sformatf("a_m[%0d]", tbl[i].idx), 64'(got_m_a[tbl[i].idx]), 64'(tbl[i].m));
            check($sformatf("a_b[%0d]", tbl[i].idx), 64'(got_b_a[tbl[i].idx]), 64'(tbl[i].b));
        end

        for (int r = 0; r < 3; r++) begin
            cnt_b = 0; sum_b = '0; rmode_b = 1;
            pulse_start_b();
            wait_done_b(2000);
            check("b_rand_count", 64'(cnt_b), 64'(NB));
`ifdef RECIPROCAL_LUT_BUILDER_CHECKSUM_EN
            check("b_checksum", 64'(cs_b), 64'(sum_b));
`endif
            repeat (3) @(posedge clk);
            #1;
        end

        cnt_b = 0; sum_b = '0; rmode_b = 1;
        pulse_start_b();
        repeat (98) begin
            @(posedge clk); #1;
        end
        rmode_b = 2;
        @(posedge clk); #1;
        rst_b = 1'b1;
        @(posedge clk); #1;
        rst_b = 1'b0;
        check("b_abort_valid", 64'(val_b), 64'd0);
        check("b_abort_busy", 64'(busy_b), 64'd0);
        cnt_b = 0; sum_b = '0; rmode_b = 0;
        pulse_start_b();
        wait_done_b(2000);
        check("b_rebuild_count", 64'(cnt_b), 64'(NB));
`ifdef RECIPROCAL_LUT_BUILDER_CHECKSUM_EN
        check("b_rebuild_checksum", 64'(cs_b), 64'(sum_b));
`endif

        repeat (2) @(posedge clk);
        #1;
        cnt_b = 0; sum_b = '0; rmode_b = 1;
        pulse_start_b();
        repeat (40) begin
            @(posedge clk); #1;
        end
        pulse_start_b();
        check("b_busy_after_extra_start", 64'(busy_b), 64'd1);
        wait_done_b(2000);
        pulse_start_b();
        check("b_no_restart_busy", 64'(busy_b), 64'd0);
        check("b_no_restart_done", 64'(done_b), 64'd0);
        repeat (40) begin
            @(posedge clk); #1;
        end
        check("b_idle_valid", 64'(val_b), 64'd0);
        check("b_ignored_count", 64'(cnt_b), 64'(NB));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
